// File: rtl/fft_pkg.sv
// Shared constants, types and address widths for the 16-point radix-2 FFT
// sequencer, sample RAM wrapper, twiddle LUT and butterfly datapath.
package fft_pkg;

  localparam int LOG2N      = 4;
  localparam int N          = 1 << LOG2N;
  localparam int NUM_BF     = N / 2;
  localparam int NUM_STAGES = LOG2N;

  localparam int ADDR_W  = LOG2N;               // sample RAM address width
  localparam int TW_W    = LOG2N - 1;           // twiddle LUT address width
  localparam int STAGE_W = $clog2(NUM_STAGES);  // stage index width
  localparam int BF_W    = $clog2(NUM_BF);      // butterfly index width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One entry of the read-to-write-back delay line.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
  } wb_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> operand
// addresses and twiddle index for an in-place radix-2 DIT FFT.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [BF_W-1:0]    k,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic [TW_W-1:0]    tw_addr
);

  logic [ADDR_W-1:0]  k_ext;
  logic [ADDR_W-1:0]  span;
  logic [ADDR_W-1:0]  pos;
  logic [ADDR_W-1:0]  grp;
  logic [ADDR_W-1:0]  tw_full;
  logic [STAGE_W:0]   grp_shift;

  // span = 2^s, pos = k mod span, grp = k >> s; a = grp*2*span + pos.
  always_comb begin
    k_ext     = ADDR_W'(k);
    span      = ADDR_W'(1) << stage;
    pos       = k_ext & (span - ADDR_W'(1));
    grp       = k_ext >> stage;
    grp_shift = {1'b0, stage} + {{STAGE_W{1'b0}}, 1'b1};
    addr_a    = (grp << grp_shift) | pos;
    addr_b    = addr_a + span;
    tw_full   = pos << (STAGE_W'(TW_W) - stage);
    tw_addr   = tw_full[TW_W-1:0];
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for the 16-point in-place FFT. Issues one
// butterfly read per cycle, drains BF_LAT cycles between stages so the next
// stage never reads ahead of the previous stage's write-back, and replays
// the read addresses BF_LAT cycles later as write-back strobes.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int BF_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr_a,
  output logic [ADDR_W-1:0]  rd_addr_b,
  output logic [TW_W-1:0]    tw_addr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr_a,
  output logic [ADDR_W-1:0]  wr_addr_b
);

  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  state_t             state_r, state_n;
  logic [STAGE_W-1:0] stage_r, stage_n;
  logic [BF_W-1:0]    k_r, k_n;
  logic [DW-1:0]      dcnt_r, dcnt_n;

  logic [ADDR_W-1:0]  gen_a;
  logic [ADDR_W-1:0]  gen_b;
  logic [TW_W-1:0]    gen_tw;

  wb_t                line_r [BF_LAT];

  fft_addr_gen u_addr_gen (
    .stage   (stage_r),
    .k       (k_r),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      stage_r <= {STAGE_W{1'b0}};
      k_r     <= {BF_W{1'b0}};
      dcnt_r  <= {DW{1'b0}};
    end else begin
      state_r <= state_n;
      stage_r <= stage_n;
      k_r     <= k_n;
      dcnt_r  <= dcnt_n;
    end
  end

  // Next-state and counter update: IDLE -> ISSUE x8 -> DRAIN xBF_LAT -> ... -> DONE.
  always_comb begin
    state_n = state_r;
    stage_n = stage_r;
    k_n     = k_r;
    dcnt_n  = dcnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          stage_n = {STAGE_W{1'b0}};
          k_n     = {BF_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (k_r == BF_W'(NUM_BF - 1)) begin
          state_n = DRAIN;
          k_n     = {BF_W{1'b0}};
          dcnt_n  = {DW{1'b0}};
        end else begin
          k_n = k_r + BF_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_r == DW'(BF_LAT - 1)) begin
          dcnt_n = {DW{1'b0}};
          if (stage_r == STAGE_W'(NUM_STAGES - 1)) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            stage_n = stage_r + STAGE_W'(1);
          end
        end else begin
          dcnt_n = dcnt_r + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        stage_n = {STAGE_W{1'b0}};
      end
      default: begin
        state_n = IDLE;
        stage_n = {STAGE_W{1'b0}};
        k_n     = {BF_W{1'b0}};
        dcnt_n  = {DW{1'b0}};
      end
    endcase
  end

  // Outputs decode straight from registers, so reset clears them at once.
  always_comb begin
    busy      = (state_r != IDLE);
    done      = (state_r == DONE);
    stage     = stage_r;
    rd_en     = (state_r == ISSUE);
    rd_addr_a = rd_en ? gen_a  : {ADDR_W{1'b0}};
    rd_addr_b = rd_en ? gen_b  : {ADDR_W{1'b0}};
    tw_addr   = rd_en ? gen_tw : {TW_W{1'b0}};
    wr_en     = line_r[BF_LAT-1].en;
    wr_addr_a = line_r[BF_LAT-1].addr_a;
    wr_addr_b = line_r[BF_LAT-1].addr_b;
  end

  // Write-back delay line: read issue in cycle t reappears as write in t+BF_LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) begin
        line_r[i] <= '0;
      end
    end else begin
      line_r[0] <= '{en: rd_en, addr_a: rd_addr_a, addr_b: rd_addr_b};
      for (int i = 1; i < BF_LAT; i++) begin
        line_r[i] <= line_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: table of expected butterfly addresses
// per stage/k, cycle-exact read/write/done timing, back-to-back starts,
// mid-transform reset and BF_LAT=1/6 instances.
module tb_fft_stage_ctrl;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
  } vec_t;

  vec_t vec [32];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start_x;

  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_a, rd_b, wr_a, wr_b;
  logic [2:0] tw;

  logic       busy1, done1, rd_en1, wr_en1;
  logic [1:0] stage1;
  logic [3:0] rd_a1, rd_b1, wr_a1, wr_b1;
  logic [2:0] tw1;

  logic       busy6, done6, rd_en6, wr_en6;
  logic [1:0] stage6;
  logic [3:0] rd_a6, rd_b6, wr_a6, wr_b6;
  logic [2:0] tw6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.BF_LAT(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .tw_addr(tw),
    .wr_en(wr_en), .wr_addr_a(wr_a), .wr_addr_b(wr_b)
  );

  fft_stage_ctrl #(.BF_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_x), .busy(busy1), .done(done1), .stage(stage1),
    .rd_en(rd_en1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .tw_addr(tw1),
    .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1)
  );

  fft_stage_ctrl #(.BF_LAT(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start_x), .busy(busy6), .done(done6), .stage(stage6),
    .rd_en(rd_en6), .rd_addr_a(rd_a6), .rd_addr_b(rd_b6), .tw_addr(tw6),
    .wr_en(wr_en6), .wr_addr_a(wr_a6), .wr_addr_b(wr_b6)
  );

  task automatic chk(input string name, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  // Butterfly index read in cycle c for drain length lat, or -1 if none.
  function automatic int rd_idx(input int c, input int lat);
    for (int s = 0; s < 4; s++) begin
      int base;
      base = 1 + (8 + lat) * s;
      if (c >= base && c <= base + 7) return s * 8 + (c - base);
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ri, wi, m;

    // Expected {addr_a, addr_b, tw} for stage s = i/8, k = i%8.
    vec[0]  = '{4'd0, 4'd1, 3'd0};   vec[1]  = '{4'd2, 4'd3, 3'd0};
    vec[2]  = '{4'd4, 4'd5, 3'd0};   vec[3]  = '{4'd6, 4'd7, 3'd0};
    vec[4]  = '{4'd8, 4'd9, 3'd0};   vec[5]  = '{4'd10, 4'd11, 3'd0};
    vec[6]  = '{4'd12, 4'd13, 3'd0}; vec[7]  = '{4'd14, 4'd15, 3'd0};
    vec[8]  = '{4'd0, 4'd2, 3'd0};   vec[9]  = '{4'd1, 4'd3, 3'd4};
    vec[10] = '{4'd4, 4'd6, 3'd0};   vec[11] = '{4'd5, 4'd7, 3'd4};
    vec[12] = '{4'd8, 4'd10, 3'd0};  vec[13] = '{4'd9, 4'd11, 3'd4};
    vec[14] = '{4'd12, 4'd14, 3'd0}; vec[15] = '{4'd13, 4'd15, 3'd4};
    vec[16] = '{4'd0, 4'd4, 3'd0};   vec[17] = '{4'd1, 4'd5, 3'd2};
    vec[18] = '{4'd2, 4'd6, 3'd4};   vec[19] = '{4'd3, 4'd7, 3'd6};
    vec[20] = '{4'd8, 4'd12, 3'd0};  vec[21] = '{4'd9, 4'd13, 3'd2};
    vec[22] = '{4'd10, 4'd14, 3'd4}; vec[23] = '{4'd11, 4'd15, 3'd6};
    vec[24] = '{4'd0, 4'd8, 3'd0};   vec[25] = '{4'd1, 4'd9, 3'd1};
    vec[26] = '{4'd2, 4'd10, 3'd2};  vec[27] = '{4'd3, 4'd11, 3'd3};
    vec[28] = '{4'd4, 4'd12, 3'd4};  vec[29] = '{4'd5, 4'd13, 3'd5};
    vec[30] = '{4'd6, 4'd14, 3'd6};  vec[31] = '{4'd7, 4'd15, 3'd7};

    // Reset and check idle state.
    rst = 1'b1; start = 1'b0; start_x = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("reset_busy", 0, int'(busy), 0);
    chk("reset_done", 0, int'(done), 0);
    chk("reset_rd_en", 0, int'(rd_en), 0);
    chk("reset_wr_en", 0, int'(wr_en), 0);
    chk("reset_stage", 0, int'(stage), 0);

    // Single transform; extra start pulses at 20 (busy) and 45 (DONE) must be ignored.
    start = 1'b1; start_x = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      ri = rd_idx(c, 3);
      wi = rd_idx(c - 3, 3);
      chk("rd_en", c, int'(rd_en), int'(ri >= 0));
      if (ri >= 0) begin
        chk("rd_addr_a", c, int'(rd_a), int'(vec[ri].a));
        chk("rd_addr_b", c, int'(rd_b), int'(vec[ri].b));
        chk("tw_addr", c, int'(tw), int'(vec[ri].tw));
        chk("stage", c, int'(stage), ri / 8);
      end else begin
        chk("rd_addr_a_idle", c, int'(rd_a), 0);
        chk("rd_addr_b_idle", c, int'(rd_b), 0);
      end
      chk("wr_en", c, int'(wr_en), int'(wi >= 0));
      if (wi >= 0) begin
        chk("wr_addr_a", c, int'(wr_a), int'(vec[wi].a));
        chk("wr_addr_b", c, int'(wr_b), int'(vec[wi].b));
      end
      chk("done", c, int'(done), int'(c == 45));
      chk("busy", c, int'(busy), int'(c >= 1 && c <= 45));
      chk("lat1_rd_en", c, int'(rd_en1), int'(rd_idx(c, 1) >= 0));
      chk("lat1_wr_en", c, int'(wr_en1), int'(rd_idx(c - 1, 1) >= 0));
      chk("lat1_done", c, int'(done1), int'(c == 37));
      chk("lat6_rd_en", c, int'(rd_en6), int'(rd_idx(c, 6) >= 0));
      chk("lat6_wr_en", c, int'(wr_en6), int'(rd_idx(c - 6, 6) >= 0));
      chk("lat6_done", c, int'(done6), int'(c == 57));
      start   = (c == 20 || c == 45);
      start_x = 1'b0;
    end

    // start held high: back-to-back transforms, done every 46 cycles.
    start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      tick();
      m = (c - 1) % 46;
      chk("b2b_done", c, int'(done), int'(m == 44));
      chk("b2b_busy", c, int'(busy), int'(m <= 44));
    end
    start = 1'b0;

    // Reset mid-transform: outputs clear immediately, no stray writes after.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
    end
    chk("pre_rst_wr_en", 20, int'(wr_en), 1);
    chk("pre_rst_busy", 20, int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 20, int'(busy), 0);
    chk("rst_done", 20, int'(done), 0);
    chk("rst_rd_en", 20, int'(rd_en), 0);
    chk("rst_wr_en", 20, int'(wr_en), 0);
    chk("rst_stage", 20, int'(stage), 0);
    chk("rst_rd_a", 20, int'(rd_a), 0);
    chk("rst_rd_b", 20, int'(rd_b), 0);
    chk("rst_tw", 20, int'(tw), 0);
    chk("rst_wr_a", 20, int'(wr_a), 0);
    chk("rst_wr_b", 20, int'(wr_b), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("post_rst_wr_en", c, int'(wr_en), 0);
      chk("post_rst_rd_en", c, int'(rd_en), 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_rd_en", 1, int'(rd_en), 1);
    chk("restart_stage", 1, int'(stage), 0);
    chk("restart_rd_a", 1, int'(rd_a), 0);
    chk("restart_rd_b", 1, int'(rd_b), 1);
    tick();
    chk("restart_rd_a_k1", 2, int'(rd_a), 2);
    chk("restart_rd_b_k1", 2, int'(rd_b), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
